md_unit: RTL and testbench

Multiply/divide unit in the E stage of the P7 five-stage MIPS pipeline, executing the HI/LO-class operations that the instruction decoder selects through `HILOOp`. It performs signed and unsigned multiply and divide with fixed multi-cycle latency and owns the HI and LO registers. It reports `Start`/`Busy` so the hazard unit can stall later HI/LO-class instructions in D, and it returns HI/LO to the pipeline for `mfhi`/`mflo`.

---
 rtl/md_unit.sv | 189 ++++++++++++++++++
 tb/tb_md_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// Multiply/divide unit for the E stage of the P7 five-stage MIPS pipeline.
// Owns the HI/LO registers, runs mult/multu/div/divu with a fixed busy
// latency, and services mthi/mtlo/mfhi/mflo.
//
// Optional feature macro: MDU_MADD_EN
//   When defined, codes 9..12 run madd/maddu/msub/msubu. These accumulate
//   into {HI,LO}.
//   When undefined, codes 9..12 behave as no-ops.
//
// Parameters:
//   MULT_CYCLES  busy cycles for multiply-class operations (1..15)
//   DIV_CYCLES   busy cycles for divide-class operations (1..15)
//
// Ports:
//   clk     sole clock, rising edge
//   reset   asynchronous active-low reset
//   HILOOp  4-bit operation code from the decoder
//   A, B    forwarded rs/rt operands
//   Req     flush of the E-stage instruction this cycle
//   Start   combinational, high when an mdu operation is accepted
//   Busy    high while an operation is in flight
//   HI, LO  current HI/LO registers
//   Out     HI for mfhi, LO for mflo, otherwise 0
// ---------------------------------------------------------------------------
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  HILOOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Req,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] Out
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } opCode_t;

   opCode_t     effOp;
   logic [3:0]  count;
   logic [31:0] hiReg, loReg;
   logic [31:0] pendHi, pendLo;
   logic        pendWrite;

   logic        isMultClass, isDivClass, idle;
   logic [63:0] prodS, prodU;
   logic [31:0] absA, absB, divisorS, divisorU;
   logic [31:0] qMag, rMag, qS, rS, qU, rU;
   logic [31:0] nextHi, nextLo;
   logic        nextWrite;

   // While reset is held the opcode is forced to none, so Start and Out stay
   // quiet even if the decoder is presenting something.
   always_comb begin
      effOp = reset ? opCode_t'(HILOOp) : OP_NONE;
   end

   // Classify the opcode and derive the accept strobe. The accumulate codes
   // only count as multiply-class when the feature is built in.
   always_comb begin
      isMultClass = 1'b0;
      isDivClass  = 1'b0;
      case (effOp)
         OP_MULT, OP_MULTU: isMultClass = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: isMultClass = 1'b1;
`endif
         OP_DIV, OP_DIVU:   isDivClass  = 1'b1;
         default: ;
      endcase
      idle  = (count == 4'd0);
      Busy  = ~idle;
      Start = (isMultClass | isDivClass) & idle & ~Req;
   end

   // Arithmetic datapath. Signed divide works on magnitudes and then fixes
   // the signs, so the 0x80000000 / -1 case falls out as quotient
   // 0x80000000, remainder 0 with no special handling. Divisors of zero are
   // replaced by one only to keep the simulator free of X; the result is
   // discarded anyway.
   always_comb begin
      prodS    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      prodU    = {32'd0, A} * {32'd0, B};
      absA     = A[31] ? (~A + 32'd1) : A;
      absB     = B[31] ? (~B + 32'd1) : B;
      divisorS = (absB == 32'd0) ? 32'd1 : absB;
      divisorU = (B == 32'd0) ? 32'd1 : B;
      qMag     = absA / divisorS;
      rMag     = absA % divisorS;
      qS       = (A[31] ^ B[31]) ? (~qMag + 32'd1) : qMag;
      rS       = A[31] ? (~rMag + 32'd1) : rMag;
      qU       = A / divisorU;
      rU       = A % divisorU;
   end

   // Result that will be parked in the pending registers on acceptance.
   // Divide by zero clears nextWrite so HI/LO survive the full latency.
   always_comb begin
      nextHi    = hiReg;
      nextLo    = loReg;
      nextWrite = 1'b1;
      case (effOp)
         OP_MULT:  {nextHi, nextLo} = prodS;
         OP_MULTU: {nextHi, nextLo} = prodU;
         OP_DIV: begin
            if (B == 32'd0) nextWrite = 1'b0;
            else begin
               nextHi = rS;
               nextLo = qS;
            end
         end
         OP_DIVU: begin
            if (B == 32'd0) nextWrite = 1'b0;
            else begin
               nextHi = rU;
               nextLo = qU;
            end
         end
`ifdef MDU_MADD_EN
         OP_MADD:  {nextHi, nextLo} = {hiReg, loReg} + prodS;
         OP_MADDU: {nextHi, nextLo} = {hiReg, loReg} + prodU;
         OP_MSUB:  {nextHi, nextLo} = {hiReg, loReg} - prodS;
         OP_MSUBU: {nextHi, nextLo} = {hiReg, loReg} - prodU;
`endif
         default: nextWrite = 1'b0;
      endcase
   end

   // Countdown, pending result and HI/LO. An accepted operation loads the
   // counter; the pending value lands in HI/LO on the 1->0 step. mthi/mtlo
   // are only honoured while idle and not flushed, and a flush never touches
   // an operation that is already counting down.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= 4'd0;
         hiReg     <= 32'd0;
         loReg     <= 32'd0;
         pendHi    <= 32'd0;
         pendLo    <= 32'd0;
         pendWrite <= 1'b0;
      end else if (Start) begin
         count     <= isMultClass ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
         pendHi    <= nextHi;
         pendLo    <= nextLo;
         pendWrite <= nextWrite;
      end else if (!idle) begin
         count <= count - 4'd1;
         if (count == 4'd1 && pendWrite) begin
            hiReg <= pendHi;
            loReg <= pendLo;
         end
      end else if (!Req) begin
         if (effOp == OP_MTHI) hiReg <= A;
         if (effOp == OP_MTLO) loReg <= A;
      end
   end

   // Read-back path for mfhi/mflo; during a busy period this naturally
   // returns the old HI/LO since the registers have not been updated yet.
   always_comb begin
      HI  = hiReg;
      LO  = loReg;
      Out = 32'd0;
      if (effOp == OP_MFHI) Out = hiReg;
      else if (effOp == OP_MFLO) Out = loReg;
   end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
// Directed self-checking bench for md_unit with default latencies
// (multiply 5, divide 10). Expected values are hand-computed constants.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_md_unit;

   logic        clk;
   logic        reset;
   logic [3:0]  HILOOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        Req;
   logic        Start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] Out;

   int errorCount = 0;
   int checkCount = 0;
   int busyCycles;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .HILOOp (HILOOp),
      .A      (A),
      .B      (B),
      .Req    (Req),
      .Start  (Start),
      .Busy   (Busy),
      .HI     (HI),
      .LO     (LO),
      .Out    (Out)
   );

   // 10-unit clock period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's worth of inputs just after the next rising edge
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic req);
      @(posedge clk);
      #1;
      HILOOp = op;
      A      = a;
      B      = b;
      Req    = req;
   endtask

   // Count busy cycles starting at the current cycle's falling edge;
   // returns at the falling edge of the first non-busy cycle.
   task automatic waitIdle(output int n);
      n = 0;
      @(negedge clk);
      while (Busy && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Issue one mdu operation, check the accept strobe and latency, and
   // check HI/LO once it completes.
   task automatic runOp(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int expCycles, input logic [31:0] expHi,
                        input logic [31:0] expLo);
      int n;
      applyStimulus(op, a, b, 1'b0);
      @(negedge clk);
      checkOutput({tag, ".start"}, {31'd0, Start}, 32'd1);
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      waitIdle(n);
      checkOutput({tag, ".cycles"}, 32'(n), 32'(expCycles));
      checkOutput({tag, ".hi"}, HI, expHi);
      checkOutput({tag, ".lo"}, LO, expLo);
   endtask

   // Main directed sequence
   initial begin
      reset  = 1'b0;
      HILOOp = 4'd1;
      A      = 32'd3;
      B      = 32'd4;
      Req    = 1'b0;

      // Reset state: opcode forced to none while reset is held
      #12;
      checkOutput("rst.start", {31'd0, Start}, 32'd0);
      checkOutput("rst.busy", {31'd0, Busy}, 32'd0);
      HILOOp = 4'd5;
      #1;
      checkOutput("rst.out", Out, 32'd0);
      checkOutput("rst.hi", HI, 32'd0);
      checkOutput("rst.lo", LO, 32'd0);
      HILOOp = 4'd0;
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Signed and unsigned multiply
      runOp("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      runOp("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);

      // Signed and unsigned divide, plus the overflow corner
      runOp("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      runOp("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
      runOp("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

      // mthi then divide by zero keeps HI/LO
      applyStimulus(4'd7, 32'h1234_5678, 32'd0, 1'b0);
      applyStimulus(4'd5, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("mthi.out", Out, 32'h1234_5678);
      runOp("div0", 4'd3, 32'd55, 32'd0, 10, 32'h1234_5678, 32'h8000_0000);
      applyStimulus(4'd5, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("div0.mfhi", Out, 32'h1234_5678);

      // Flushed mult and flushed mtlo do nothing
      applyStimulus(4'd1, 32'd9, 32'd9, 1'b1);
      @(negedge clk);
      checkOutput("req.start", {31'd0, Start}, 32'd0);
      applyStimulus(4'd8, 32'hDEAD_BEEF, 32'd0, 1'b1);
      @(negedge clk);
      checkOutput("req.busy", {31'd0, Busy}, 32'd0);
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("req.busy2", {31'd0, Busy}, 32'd0);
      checkOutput("req.hi", HI, 32'h1234_5678);
      checkOutput("req.lo", LO, 32'h8000_0000);

      // mult 3x4 with an mtlo during busy cycle 2 (ignored), mflo old LO
      applyStimulus(4'd1, 32'd3, 32'd4, 1'b0);
      @(negedge clk);
      checkOutput("mt.start", {31'd0, Start}, 32'd1);
      applyStimulus(4'd6, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("mt.busy1", {31'd0, Busy}, 32'd1);
      checkOutput("mt.mflo", Out, 32'h8000_0000);
      applyStimulus(4'd8, 32'h0000_AAAA, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("mt.start2", {31'd0, Start}, 32'd0);
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      waitIdle(busyCycles);
      checkOutput("mt.cycles", 32'(busyCycles), 32'd3);
      checkOutput("mt.lo", LO, 32'd12);
      checkOutput("mt.hi", HI, 32'd0);

      // Back-to-back: divu held during a mult is accepted in the first idle cycle
      applyStimulus(4'd1, 32'd5, 32'd6, 1'b0);
      applyStimulus(4'd4, 32'd30, 32'd4, 1'b0);
      busyCycles = 0;
      @(negedge clk);
      while (Busy && busyCycles < 40) begin
         busyCycles++;
         checkOutput("b2b.held", {31'd0, Start}, 32'd0);
         @(negedge clk);
      end
      checkOutput("b2b.cycles", 32'(busyCycles), 32'd5);
      checkOutput("b2b.start", {31'd0, Start}, 32'd1);
      checkOutput("b2b.lo", LO, 32'd30);
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      waitIdle(busyCycles);
      checkOutput("b2b.divcyc", 32'(busyCycles), 32'd10);
      checkOutput("b2b.hi", HI, 32'd2);
      checkOutput("b2b.lo2", LO, 32'd7);

      // Reset in busy cycle 3 of a divide discards the result
      applyStimulus(4'd3, 32'd100, 32'd7, 1'b0);
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rstmid.busy", {31'd0, Busy}, 32'd0);
      checkOutput("rstmid.hi", HI, 32'd0);
      checkOutput("rstmid.lo", LO, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("rstmid.late_hi", HI, 32'd0);
      checkOutput("rstmid.late_lo", LO, 32'd0);
      checkOutput("rstmid.late_busy", {31'd0, Busy}, 32'd0);

`ifdef MDU_MADD_EN
      // Accumulate: LO=5 then madd 2x3 gives 11; msubu 1x12 wraps to -1
      applyStimulus(4'd8, 32'd5, 32'd0, 1'b0);
      runOp("madd", 4'd9, 32'd2, 32'd3, 5, 32'd0, 32'd11);
      runOp("msubu", 4'd12, 32'd1, 32'd12, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
      // Accumulate codes are no-ops in this build
      applyStimulus(4'd9, 32'd2, 32'd3, 1'b0);
      @(negedge clk);
      checkOutput("madd.off.start", {31'd0, Start}, 32'd0);
      applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("madd.off.busy", {31'd0, Busy}, 32'd0);
      checkOutput("madd.off.lo", LO, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
